// File: rtl/mix_phase_accum.sv
// Time-multiplexed NCH-channel phase accumulator streaming truncated phases over AXI-Stream.
// Optional build macro MIX_PHASE_DITHER_EN adds LFSR dither below the output LSB before truncation.
module mix_phase_accum #(
    parameter int NCH     = 16,
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     cfg_wr_en,
    input  logic [$clog2(NCH)-1:0]   cfg_wr_ch,
    input  logic [PHASE_W-1:0]       cfg_wr_freq,
    input  logic                     cfg_sync,
    input  logic                     run_en,
    output logic [OUT_W-1:0]         m_axis_tdata,
    output logic [$clog2(NCH)-1:0]   m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
);
    localparam int CH_W = $clog2(NCH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

    state_t             state_reg, state_next;
    logic [CH_W-1:0]    ch_reg, ch_next;
    logic               sync_pend_reg, sync_pend_next;
    logic               tvalid_reg, tvalid_next;
    logic [OUT_W-1:0]   tdata_reg;
    logic [CH_W-1:0]    tuser_reg;
    logic               tlast_reg;
    logic [PHASE_W-1:0] phase_tab [NCH];
    logic [PHASE_W-1:0] out_phase;
    logic               xfer, at_last, clr_en, load_out;

    assign xfer    = tvalid_reg && m_axis_tready;
    assign at_last = (ch_reg == LAST_CH);

    // Per-channel frequency and phase registers; ch_reg selects the channel being cleared or advanced.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [PHASE_W-1:0] freq_r;
            logic [PHASE_W-1:0] phase_r;
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    freq_r  <= '0;
                    phase_r <= '0;
                end else begin
                    if (cfg_wr_en && (cfg_wr_ch == CH_W'(gi)))
                        freq_r <= cfg_wr_freq;
                    if (clr_en && (ch_reg == CH_W'(gi)))
                        phase_r <= '0;
                    else if (xfer && (ch_reg == CH_W'(gi)))
                        phase_r <= phase_r + freq_r;
                end
            end
            assign phase_tab[gi] = phase_r;
        end
    endgenerate

`ifdef MIX_PHASE_DITHER_EN
    localparam int FRAC_W = PHASE_W - OUT_W;
    logic [15:0]        lfsr_reg;
    logic [PHASE_W-1:0] dither;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            lfsr_reg <= 16'hACE1;
        else if (xfer)
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end

    // Align the LFSR so its MSB sits just below the output LSB (always less than one output LSB).
    generate
        if (FRAC_W >= 16) begin : g_dither_wide
            assign dither = PHASE_W'(lfsr_reg) << (FRAC_W - 16);
        end else begin : g_dither_narrow
            assign dither = PHASE_W'(lfsr_reg >> (16 - FRAC_W));
        end
    endgenerate

    assign out_phase = phase_tab[ch_next] + dither;
`else
    assign out_phase = phase_tab[ch_next];
`endif

    always_comb begin
        state_next     = state_reg;
        ch_next        = ch_reg;
        sync_pend_next = sync_pend_reg;
        tvalid_next    = tvalid_reg;
        clr_en         = 1'b0;
        load_out       = 1'b0;
        case (state_reg)
            IDLE: begin
                ch_next        = '0;
                sync_pend_next = 1'b0;
                if (run_en)
                    state_next = CLEAR;
            end
            CLEAR: begin
                clr_en         = 1'b1;
                sync_pend_next = 1'b0;
                ch_next        = ch_reg + 1'b1;
                if (at_last)
                    state_next = RUN;
            end
            RUN: begin
                if (cfg_sync)
                    sync_pend_next = 1'b1;
                if (!tvalid_reg) begin
                    load_out    = 1'b1;
                    tvalid_next = 1'b1;
                end else if (xfer) begin
                    ch_next = ch_reg + 1'b1;
                    // Frame boundaries are the only place a stop or resync may take effect.
                    if (at_last && !run_en) begin
                        state_next     = IDLE;
                        tvalid_next    = 1'b0;
                        sync_pend_next = 1'b0;
                    end else if (at_last && (sync_pend_reg || cfg_sync)) begin
                        state_next     = CLEAR;
                        tvalid_next    = 1'b0;
                        sync_pend_next = 1'b0;
                    end else begin
                        load_out = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg     <= IDLE;
            ch_reg        <= '0;
            sync_pend_reg <= 1'b0;
            tvalid_reg    <= 1'b0;
            tdata_reg     <= '0;
            tuser_reg     <= '0;
            tlast_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ch_reg        <= ch_next;
            sync_pend_reg <= sync_pend_next;
            tvalid_reg    <= tvalid_next;
            if (load_out) begin
                tdata_reg <= out_phase[PHASE_W-1 -: OUT_W];
                tuser_reg <= ch_next;
                tlast_reg <= (ch_next == LAST_CH);
            end
        end
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tuser  = tuser_reg;
    assign m_axis_tlast  = tlast_reg;
    assign m_axis_tvalid = tvalid_reg;
endmodule

// File: tb/tb_mix_phase_accum.sv
// Scoreboard bench for mix_phase_accum (NCH=4, PHASE_W=32, OUT_W=16).
module tb_mix_phase_accum;
    localparam int NCH     = 4;
    localparam int PHASE_W = 32;
    localparam int OUT_W   = 16;

    logic               ACLK = 1'b0;
    logic               ARESETN = 1'b0;
    logic               cfg_wr_en = 1'b0;
    logic [1:0]         cfg_wr_ch = '0;
    logic [PHASE_W-1:0] cfg_wr_freq = '0;
    logic               cfg_sync = 1'b0;
    logic               run_en = 1'b0;
    logic               m_axis_tready = 1'b1;
    logic [OUT_W-1:0]   m_axis_tdata;
    logic [1:0]         m_axis_tuser;
    logic               m_axis_tlast;
    logic               m_axis_tvalid;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  u;
        logic        l;
    } beat_t;

    beat_t        exp_q[$];
    logic [31:0]  freq_m  [NCH];
    logic [31:0]  phase_m [NCH];
    int           checks = 0;
    int           failures = 0;
    int           tready_mode = 0;
    logic [3:0]   tready_pat = 4'b1001;

    always #5 ACLK = ~ACLK;

    mix_phase_accum #(.NCH(NCH), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .cfg_wr_en(cfg_wr_en),
        .cfg_wr_ch(cfg_wr_ch),
        .cfg_wr_freq(cfg_wr_freq),
        .cfg_sync(cfg_sync),
        .run_en(run_en),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic write_freq(input int c, input logic [31:0] f);
        cfg_wr_en   = 1'b1;
        cfg_wr_ch   = 2'(c);
        cfg_wr_freq = f;
        tick();
        cfg_wr_en   = 1'b0;
        freq_m[c]   = f;
    endtask

    task automatic zero_model();
        for (int c = 0; c < NCH; c++) phase_m[c] = '0;
    endtask

    task automatic push_frames(input int n);
        beat_t b;
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < NCH; c++) begin
                b.d = phase_m[c][31:16];
                b.u = 2'(c);
                b.l = (c == NCH - 1);
                exp_q.push_back(b);
                phase_m[c] = phase_m[c] + freq_m[c];
            end
        end
    endtask

    // From IDLE: one IDLE cycle, NCH CLEAR cycles, one output-register cycle.
    task automatic start_stream(input string tag);
        int n;
        n = 0;
        run_en  = 1'b1;
        ARESETN = 1'b1;
        do begin
            tick();
            n++;
        end while (!m_axis_tvalid && n < 50);
        check_val(tag, 32'(n), 32'(NCH + 2));
    endtask

    task automatic finish_stream();
        int n;
        n = 0;
        while (exp_q.size() > NCH && n < 2000) begin
            tick();
            n++;
        end
        run_en = 1'b0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 4000) begin
            tick();
            n++;
        end
        check_val("drain_done", 32'(exp_q.size() == 0 && !m_axis_tvalid), 1);
        repeat (8) tick();
        check_val("idle_after_drain", 32'(m_axis_tvalid), 0);
    endtask

    initial begin : tready_drv
        int idx;
        idx = 0;
        forever begin
            @(posedge ACLK);
            #1;
            case (tready_mode)
                0: m_axis_tready = 1'b1;
                1: begin
                    m_axis_tready = tready_pat[idx];
                    idx = (idx + 1) % 4;
                end
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        beat_t       e;
        logic [19:0] held;
        logic        stall_prev;
        logic [15:0] diff;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check_val("hold_stable", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'(held));
                if (m_axis_tvalid && m_axis_tready) begin
                    $display("beat ch=%0d tdata=0x%04h tlast=%0d", m_axis_tuser, m_axis_tdata, m_axis_tlast);
                    check_val("q_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
`ifdef MIX_PHASE_DITHER_EN
                        diff = m_axis_tdata - e.d;
                        check_val("tdata_dither", 32'(diff <= 16'd1), 1);
`else
                        diff = '0;
                        check_val("tdata", 32'(m_axis_tdata), 32'(e.d));
`endif
                        check_val("tuser", 32'(m_axis_tuser), 32'(e.u));
                        check_val("tlast", 32'(m_axis_tlast), 32'(e.l));
                    end
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                held = {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast};
            end
        end
    end

    initial begin : stim
        int n;
        for (int c = 0; c < NCH; c++) freq_m[c] = '0;
        zero_model();

        repeat (3) @(posedge ACLK);
        #1;
        check_val("rst_tvalid", 32'(m_axis_tvalid), 0);
        check_val("rst_tdata", 32'(m_axis_tdata), 0);
        check_val("rst_tuser", 32'(m_axis_tuser), 0);
        check_val("rst_tlast", 32'(m_axis_tlast), 0);
        ARESETN = 1'b1;
        tick();

        // Basic ramp: 0s, then freq, then 2*freq
        for (int c = 0; c < NCH; c++) write_freq(c, 32'(c + 1) << 16);
        zero_model();
        push_frames(3);
        start_stream("latency_first");
        finish_stream();

        // Wrap on channel 1 with 1-0-0-1 backpressure
        write_freq(1, 32'hFFFF_0000);
        zero_model();
        push_frames(3);
        tready_mode = 1;
        start_stream("latency_wrap");
        finish_stream();

        // Random backpressure
        write_freq(1, 32'h0002_0000);
        write_freq(3, 32'h1234_5678);
        zero_model();
        push_frames(4);
        tready_mode = 2;
        start_stream("latency_rand");
        finish_stream();
        tready_mode = 0;
        tick();

        // Resync request on the ch1 beat
        zero_model();
        push_frames(1);
        zero_model();
        push_frames(1);
        start_stream("latency_sync");
        n = 0;
        while (!(m_axis_tvalid && m_axis_tuser == 2'd1) && n < 50) begin
            tick();
            n++;
        end
        check_val("sync_found_ch1", 32'(m_axis_tuser), 1);
        cfg_sync = 1'b1;
        tick();
        cfg_sync = 1'b0;
        n = 0;
        while (!(m_axis_tvalid && m_axis_tlast) && n < 50) begin
            tick();
            n++;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_axis_tvalid && n < 50);
        check_val("sync_clear_gap", 32'(n), 32'(NCH + 2));
        finish_stream();

        // Reset on the ch2 beat, then restart through CLEAR
        zero_model();
        push_frames(2);
        start_stream("latency_pre_rst");
        n = 0;
        while (!(m_axis_tvalid && m_axis_tuser == 2'd2) && n < 50) begin
            tick();
            n++;
        end
        check_val("rst_found_ch2", 32'(m_axis_tuser), 2);
        #1;
        ARESETN = 1'b0;
        #1;
        check_val("midrst_tvalid", 32'(m_axis_tvalid), 0);
        check_val("midrst_tdata", 32'(m_axis_tdata), 0);
        check_val("midrst_tuser", 32'(m_axis_tuser), 0);
        check_val("midrst_tlast", 32'(m_axis_tlast), 0);
        exp_q.delete();
        for (int c = 0; c < NCH; c++) freq_m[c] = '0;
        tick();
        tick();
        zero_model();
        push_frames(2);
        start_stream("latency_post_rst");
        finish_stream();

        // Recovery with nonzero frequencies after reset
        for (int c = 0; c < NCH; c++) write_freq(c, 32'(c + 5) << 15);
        zero_model();
        push_frames(2);
        start_stream("latency_recover");
        finish_stream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mix_phase_accum.md
MIX_PHASE_ACCUM -- requirements
Module: mix_phase_accum

Interface
REQ-001 SHALL have parameter NCH, default 16, number of time-multiplexed mixer channels (power of two, 2..256).
REQ-002 SHALL have parameter PHASE_W, default 32, phase accumulator and frequency word width.
REQ-003 SHALL have parameter OUT_W, default 16, output phase width (OUT_W <= PHASE_W).
REQ-004 ACLK  in  1  sole clock; all logic rising-edge.
REQ-005 ARESETN  in  1  reset, asynchronous, active-low.
REQ-006 cfg_wr_en  in  1  one-cycle strobe writing a frequency word from the mix_freq_set register block.
REQ-007 cfg_wr_ch  in  log2(NCH)  target channel of cfg_wr_en.
REQ-008 cfg_wr_freq  in  PHASE_W  frequency tuning word.
REQ-009 cfg_sync  in  1  pulse requesting all channel phases be zeroed.
REQ-010 run_en  in  1  level; enables phase streaming.
REQ-011 m_axis_tdata  out  OUT_W  truncated phase of current channel.
REQ-012 m_axis_tuser  out  log2(NCH)  channel index of beat.
REQ-013 m_axis_tlast  out  1  high on channel NCH-1 beat.
REQ-014 m_axis_tvalid / m_axis_tready  out / in  1 / 1  AXI-Stream handshake.

Function
REQ-015 SHALL hold freq[NCH] and phase[NCH] tables (PHASE_W each) plus channel counter ch.
REQ-016 SHALL implement FSM IDLE, CLEAR, RUN.
REQ-017 IDLE: tvalid=0; run_en=1 -> CLEAR.
REQ-018 CLEAR: zero phase[ch] one channel per cycle, ch 0..NCH-1, tvalid=0; after ch=NCH-1 -> RUN with ch=0.
REQ-019 RUN: a beat transfers when tvalid&&tready; on transfer ch increments modulo NCH.
REQ-020 Beat for channel c SHALL carry tdata=phase[c][PHASE_W-1:PHASE_W-OUT_W] (pre-add), tuser=c, tlast=(c==NCH-1); phase[c] SHALL update to phase[c]+freq[c] modulo 2^PHASE_W in the transfer cycle.
REQ-021 Output registered; first beat valid 1 cycle after entering RUN; with tready held high, one beat per cycle, no bubbles.
REQ-022 tready low SHALL hold tdata/tuser/tlast/tvalid stable; no phase advances.
REQ-023 cfg_wr_en SHALL write freq[cfg_wr_ch] in any state, one cycle; the write affects the next visit of that channel; a beat for the same channel in the write cycle uses the old word.
REQ-024 cfg_sync in RUN SHALL set sync_pend; on the tlast transfer with sync_pend set -> CLEAR, sync_pend cleared; cfg_sync in IDLE/CLEAR is absorbed (CLEAR already pending/active).
REQ-025 run_en low in RUN SHALL take effect only after the tlast transfer -> IDLE; frames are never truncated.
REQ-026 cfg_sync and tlast transfer in the same cycle SHALL enter CLEAR.

Reset
REQ-027 ARESETN low SHALL immediately force IDLE, ch=0, sync_pend=0, all freq and phase entries 0, tvalid=0, tdata=0, tuser=0, tlast=0.
REQ-028 Reset mid-frame SHALL discard the frame; after release, restart is via CLEAR only.

Configuration
REQ-029 Macro MIX_PHASE_DITHER_EN: when defined, a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset), advancing on each transfer, SHALL be added below bit PHASE_W-OUT_W before truncation of tdata only (accumulator unaffected); when undefined, plain truncation and no LFSR logic.

Verification (NCH=4, PHASE_W=32, OUT_W=16, dither off unless noted)
REQ-030 Reset, freq[0..3]=0x00010000,0x00020000,0x00030000,0x00040000, run_en=1, tready=1 -> 4 idle CLEAR cycles, then tdata 0,0,0,0 (tlast on 4th), then 1,2,3,4, then 2,4,6,8.
REQ-031 freq[1]=0xFFFF0000, 3 frames -> ch1 tdata 0x0000, 0xFFFF, 0xFFFE (wrap).
REQ-032 tready toggled 1-0-0-1 mid-frame -> outputs stable while low, no skipped or repeated channel.
REQ-033 cfg_sync pulse on ch1 beat -> frame completes, 4 CLEAR cycles, next frame all tdata 0.
REQ-034 ARESETN low on ch2 beat -> tvalid=0 same cycle, all outputs 0; on release with run_en=1, CLEAR then zero phases.
REQ-035 MIX_PHASE_DITHER_EN defined, all freq=0 -> tdata differs from 0 only by <=1 LSB, accumulators remain 0.
